// File: rtl/video_line_prefetch_if.sv
// Frame-memory read bus used by the line prefetcher.
// The master issues pixel-word read requests; the slave accepts them and
// returns the responses in request order.
interface video_line_prefetch_if #(
  parameter int ADDR_WIDTH = 24
);
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_ready;
  logic                  rd_data_valid;
  logic [23:0]           rd_data;

  modport master (
    output rd_req, rd_addr,
    input  rd_ready, rd_data_valid, rd_data
  );

  modport slave (
    input  rd_req, rd_addr,
    output rd_ready, rd_data_valid, rd_data
  );
endinterface

// File: rtl/video_line_prefetch.sv
// Double-buffered video line prefetcher.
// While line L is shown from bank L[0], line L+1 is fetched from frame memory
// into the other bank. A late fetch is flagged on the sticky underrun output.
module video_line_prefetch #(
  parameter int VISIBLE_WIDTH  = 400,
  parameter int VISIBLE_HEIGHT = 360,
  parameter int ADDR_WIDTH     = 24
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              en,
  input  logic                              vs,
  input  logic                              line_start,
  input  logic [$clog2(VISIBLE_HEIGHT)-1:0] y_index,
  input  logic                              y_index_valid,
  input  logic [$clog2(VISIBLE_WIDTH)-1:0]  x_index,
  input  logic                              x_index_valid,
  input  logic [ADDR_WIDTH-1:0]             fb_base,
  video_line_prefetch_if.master             rd,
  output logic [23:0]                       rgb_out,
  output logic                              underrun,
  input  logic                              underrun_clr
);
  localparam int XW = $clog2(VISIBLE_WIDTH);
  localparam int YW = $clog2(VISIBLE_HEIGHT);
  localparam int CW = $clog2(VISIBLE_WIDTH + 1);
  localparam logic [CW-1:0] LINE_LEN = CW'(VISIBLE_WIDTH);

  typedef logic [23:0] rgb_t;
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [YW-1:0]         r_fetch_line;
  logic                  r_fetch_bank;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [CW-1:0]         r_req_x;
  logic [CW-1:0]         r_wr_x;
  logic [CW-1:0]         r_outstanding;
  logic                  r_line_done;
  rgb_t                  r_rgb_p1;
  logic                  r_underrun;
  rgb_t                  r_bank0 [VISIBLE_WIDTH];
  rgb_t                  r_bank1 [VISIBLE_WIDTH];

  logic                  w_ls;
  logic                  w_start_vs;
  logic                  w_start_ls;
  logic                  w_start;
  logic [YW-1:0]         w_start_line;
  logic                  w_accept;
  logic                  w_resp;
  logic                  w_wr;
  logic [ADDR_WIDTH-1:0] w_line_off;

  // A line_start for the last visible line starts nothing; vs always restarts at line 0.
  assign w_ls         = en & line_start & y_index_valid;
  assign w_start_vs   = en & vs;
  assign w_start_ls   = w_ls & ((int'(y_index) + 1) < VISIBLE_HEIGHT);
  assign w_start      = w_start_vs | w_start_ls;
  assign w_start_line = w_start_vs ? '0 : y_index + YW'(1);

  // Responses only count against requests this block actually issued, so
  // stray responses after a reset are harmless.
  assign w_accept   = rd.rd_req & rd.rd_ready;
  assign w_resp     = rd.rd_data_valid & (r_outstanding != '0) & (r_state != IDLE);
  assign w_wr       = (r_state == REQ) & w_resp & (r_wr_x < LINE_LEN) & ~w_start;
  assign w_line_off = ADDR_WIDTH'(r_fetch_line) * ADDR_WIDTH'(VISIBLE_WIDTH);

  assign rgb_out  = r_rgb_p1;
  assign underrun = r_underrun;

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Fetch FSM next state and request outputs; requests pause during a fetch-start cycle.
  always_comb begin
    w_state_nxt = r_state;
    rd.rd_req   = 1'b0;
    rd.rd_addr  = '0;
    unique case (r_state)
      IDLE: begin
        if (w_start) w_state_nxt = REQ;
      end
      REQ: begin
        if (w_start) begin
          w_state_nxt = (r_outstanding != '0) ? DRAIN : REQ;
        end else if (r_req_x < LINE_LEN) begin
          rd.rd_req  = 1'b1;
          rd.rd_addr = r_base + w_line_off + ADDR_WIDTH'(r_req_x);
        end else if (r_outstanding == '0) begin
          w_state_nxt = IDLE;
        end
      end
      DRAIN: begin
        if (r_outstanding == '0) w_state_nxt = REQ;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Fetch bookkeeping, display pixel register and underrun flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_line  <= '0;
      r_fetch_bank  <= 1'b0;
      r_base        <= '0;
      r_req_x       <= '0;
      r_wr_x        <= '0;
      r_outstanding <= '0;
      r_line_done   <= 1'b0;
      r_rgb_p1      <= '0;
      r_underrun    <= 1'b0;
    end else begin
      if (w_accept && !w_resp)      r_outstanding <= r_outstanding + CW'(1);
      else if (!w_accept && w_resp) r_outstanding <= r_outstanding - CW'(1);

      if (w_start) begin
        r_fetch_line <= w_start_line;
        r_fetch_bank <= w_start_line[0];
        r_req_x      <= '0;
        r_wr_x       <= '0;
        r_line_done  <= 1'b0;
        if (w_start_vs) r_base <= fb_base;
      end else begin
        if (w_accept) r_req_x <= r_req_x + CW'(1);
        if (w_wr) begin
          r_wr_x <= r_wr_x + CW'(1);
          if (r_wr_x == LINE_LEN - CW'(1)) r_line_done <= 1'b1;
        end
      end

      if (en) begin
        if (!x_index_valid)  r_rgb_p1 <= '0;
        else if (y_index[0]) r_rgb_p1 <= r_bank1[x_index];
        else                 r_rgb_p1 <= r_bank0[x_index];
      end

      // The line about to be shown must be the one fetched and complete.
      if (w_ls && ((r_fetch_line != y_index) || !r_line_done)) r_underrun <= 1'b1;
      else if (underrun_clr)                                   r_underrun <= 1'b0;
    end
  end

  // Line bank write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      if (r_fetch_bank) r_bank1[r_wr_x[XW-1:0]] <= rd.rd_data;
      else              r_bank0[r_wr_x[XW-1:0]] <= rd.rd_data;
    end
  end
endmodule

// File: tb/tb_video_line_prefetch.sv
// Bench for video_line_prefetch with a 4x3 frame at base 0x100.
// A frame-memory model answers requests in order with a programmable latency;
// expected addresses and pixels are queued when stimulus is driven.
module tb_video_line_prefetch;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en, vs, line_start;
  logic [1:0]    y_index;
  logic          y_index_valid;
  logic [1:0]    x_index;
  logic          x_index_valid;
  logic [AW-1:0] fb_base;
  logic [23:0]   rgb_out;
  logic          underrun;
  logic          underrun_clr;

  video_line_prefetch_if #(.ADDR_WIDTH(AW)) rd_if ();

  video_line_prefetch #(
    .VISIBLE_WIDTH (W),
    .VISIBLE_HEIGHT(H),
    .ADDR_WIDTH    (AW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .vs           (vs),
    .line_start   (line_start),
    .y_index      (y_index),
    .y_index_valid(y_index_valid),
    .x_index      (x_index),
    .x_index_valid(x_index_valid),
    .fb_base      (fb_base),
    .rd           (rd_if.master),
    .rgb_out      (rgb_out),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [23:0]   data;
    int            due;
  } resp_t;

  typedef struct {
    logic [1:0]  y;
    logic [1:0]  x;
    logic        xv;
    logic [23:0] exp;
  } pvec_t;

  resp_t         pend[$];
  logic [AW-1:0] exp_addr[$];
  logic [23:0]   pix_q[$];
  logic [7:0]    tag   = 8'hA0;
  int            lat   = 2;
  int            limit = 1000000;
  pvec_t         tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] pxv(input int a);
    return {8'hA0, 16'(a)};
  endfunction

  // Frame memory model: in-order responses, data = {tag, addr[15:0]}.
  initial begin
    logic [AW-1:0] ea;
    rd_if.rd_ready      = 1'b0;
    rd_if.rd_data_valid = 1'b0;
    rd_if.rd_data       = '0;
    forever begin
      @(negedge clk);
      #1;
      rd_if.rd_data_valid = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        rd_if.rd_data_valid = 1'b1;
        rd_if.rd_data       = pend[0].data;
        void'(pend.pop_front());
      end
      rd_if.rd_ready = (limit > 0);
      if (rd_if.rd_req && rd_if.rd_ready) begin
        limit--;
        if (exp_addr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_addr_extra actual=%h required=no request", rd_if.rd_addr);
        end else begin
          ea = exp_addr.pop_front();
          chk("rd_addr", 32'(rd_if.rd_addr), 32'(ea));
        end
        pend.push_back('{rd_if.rd_addr, {tag, rd_if.rd_addr[15:0]}, cyc + lat});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_line(input int line, input int n);
    for (int i = 0; i < n; i++) exp_addr.push_back(AW'(32'h100 + line * W + i));
  endtask

  task automatic pulse_vs();
    vs = 1'b1;
    @(negedge clk);
    vs = 1'b0;
  endtask

  task automatic ls(input logic [1:0] y, input logic clr);
    line_start    = 1'b1;
    y_index       = y;
    y_index_valid = 1'b1;
    underrun_clr  = clr;
    @(negedge clk);
    line_start    = 1'b0;
    underrun_clr  = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    for (k = 0; k < 100; k++) begin
      if (exp_addr.size() == 0 && pend.size() == 0 && !rd_if.rd_req) break;
      @(negedge clk);
    end
    chk(nm, 32'(k < 100), 32'd1);
    tick(2);
  endtask

  task automatic pix(input logic [1:0] y, input logic [1:0] x, input logic xv,
                     input logic [23:0] exp);
    logic [23:0] e;
    en            = 1'b1;
    y_index       = y;
    x_index       = x;
    x_index_valid = xv;
    pix_q.push_back(exp);
    @(negedge clk);
    e = pix_q.pop_front();
    chk("rgb_out", 32'(rgb_out), 32'(e));
  endtask

  task automatic count_req(input string nm, input int n);
    int nreq = 0;
    repeat (n) begin
      @(negedge clk);
      if (rd_if.rd_req) nreq++;
    end
    chk(nm, 32'(nreq), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      tbl[i]     = '{2'd0, 2'(i), 1'b1, pxv(32'h100 + i)};
      tbl[4 + i] = '{2'd1, 2'(i), 1'b1, pxv(32'h104 + i)};
    end
    tbl[8] = '{2'd0, 2'd2, 1'b0, 24'h0};
    tbl[9] = '{2'd1, 2'd3, 1'b1, pxv(32'h107)};

    reset_n       = 1'b0;
    en            = 1'b1;
    vs            = 1'b0;
    line_start    = 1'b0;
    y_index       = '0;
    y_index_valid = 1'b0;
    x_index       = '0;
    x_index_valid = 1'b0;
    fb_base       = 24'h100;
    underrun_clr  = 1'b0;
    tick(3);
    chk("reset_rd_req", 32'(rd_if.rd_req), 32'd0);
    chk("reset_rd_addr", 32'(rd_if.rd_addr), 32'd0);
    chk("reset_rgb_out", 32'(rgb_out), 32'd0);
    chk("reset_underrun", 32'(underrun), 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Line 0 on vs, then line 1 on line_start of line 0.
    push_line(0, W);
    pulse_vs();
    wait_idle("fetch_line0_done");
    push_line(1, W);
    ls(2'd0, 1'b0);
    wait_idle("fetch_line1_done");
    chk("underrun_clean", 32'(underrun), 32'd0);

    for (int i = 0; i < 10; i++) pix(tbl[i].y, tbl[i].x, tbl[i].xv, tbl[i].exp);
    en      = 1'b0;
    x_index = 2'd0;
    y_index = 2'd0;
    @(negedge clk);
    chk("rgb_hold", 32'(rgb_out), 32'(pxv(32'h107)));
    en            = 1'b1;
    x_index_valid = 1'b0;

    // Last line: no fetch, and the unfetched line reads as underrun.
    ls(2'd2, 1'b0);
    count_req("no_fetch_last_line", 8);
    chk("underrun_set", 32'(underrun), 32'd1);
    tick(3);
    chk("underrun_sticky", 32'(underrun), 32'd1);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("underrun_cleared", 32'(underrun), 32'd0);

    // Drain: three requests outstanding when the next fetch starts.
    push_line(0, W);
    pulse_vs();
    wait_idle("refetch_line0_done");
    lat   = 12;
    limit = 3;
    push_line(1, 3);
    ls(2'd0, 1'b0);
    chk("underrun_line0_ok", 32'(underrun), 32'd0);
    begin
      int k;
      for (k = 0; k < 20; k++) begin
        if (exp_addr.size() == 0) break;
        @(negedge clk);
      end
      chk("three_accepts", 32'(k < 20), 32'd1);
    end
    tick(2);
    push_line(2, W);
    limit = 1000000;
    lat   = 2;
    ls(2'd1, 1'b0);
    chk("underrun_late_line1", 32'(underrun), 32'd1);
    wait_idle("drain_then_line2_done");
    for (int i = 0; i < 4; i++) pix(2'd2, 2'(i), 1'b1, pxv(32'h108 + i));

    // A new underrun in the same cycle as the clear wins.
    push_line(1, W);
    ls(2'd0, 1'b1);
    chk("underrun_set_beats_clr", 32'(underrun), 32'd1);
    wait_idle("fetch_line1_again_done");
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("underrun_cleared2", 32'(underrun), 32'd0);

    // Reset mid-fetch: late responses with a new tag must not reach bank1.
    pix(2'd0, 2'd0, 1'b1, pxv(32'h108));
    tag = 8'h55;
    lat = 12;
    push_line(1, W);
    ls(2'd0, 1'b0);
    tick(2);
    reset_n = 1'b0;
    #1;
    chk("midreset_rd_req", 32'(rd_if.rd_req), 32'd0);
    chk("midreset_rd_addr", 32'(rd_if.rd_addr), 32'd0);
    chk("midreset_rgb_out", 32'(rgb_out), 32'd0);
    exp_addr.delete();
    tick(2);
    reset_n = 1'b1;
    chk("midreset_underrun", 32'(underrun), 32'd0);
    count_req("no_fetch_after_reset", 20);
    chk("strays_delivered", 32'(pend.size()), 32'd0);
    for (int i = 0; i < 4; i++) pix(2'd1, 2'(i), 1'b1, pxv(32'h104 + i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
